// File: rtl/cdec_ctrl_pkg.sv
// Shared encodings for the CDEC control unit: state codes, Xbus endpoints,
// ALU op codes, instruction field positions and jump condition codes.
package cdec_ctrl_pkg;

    typedef logic [2:0] ctrl_state_t;

    localparam ctrl_state_t ST_F0   = 3'd0;
    localparam ctrl_state_t ST_F1   = 3'd1;
    localparam ctrl_state_t ST_F2   = 3'd2;
    localparam ctrl_state_t ST_E0   = 3'd3;
    localparam ctrl_state_t ST_E1   = 3'd4;
    localparam ctrl_state_t ST_E2   = 3'd5;
    localparam ctrl_state_t ST_HALT = 3'd6;

    localparam logic [2:0] XSRC_PC  = 3'd0;
    localparam logic [2:0] XSRC_A   = 3'd1;
    localparam logic [2:0] XSRC_B   = 3'd2;
    localparam logic [2:0] XSRC_C   = 3'd3;
    localparam logic [2:0] XSRC_R   = 3'd4;
    localparam logic [2:0] XSRC_RD  = 3'd5;
    localparam logic [2:0] XSRC_FLG = 3'd6;
    localparam logic [2:0] XSRC_FF  = 3'd7;

    localparam logic [2:0] XDST_PC  = 3'd0;
    localparam logic [2:0] XDST_A   = 3'd1;
    localparam logic [2:0] XDST_B   = 3'd2;
    localparam logic [2:0] XDST_C   = 3'd3;
    localparam logic [2:0] XDST_MAR = 3'd4;
    localparam logic [2:0] XDST_WDR = 3'd5;
    localparam logic [2:0] XDST_T   = 3'd6;
    localparam logic [2:0] XDST_I   = 3'd7;

    localparam logic [3:0] ALUOP_NONE = 4'b0000;
    localparam logic [3:0] ALUOP_INC  = 4'b1000;

    // A sink cycle parks FFh in T, which is always reloaded before ALU use.
    localparam logic [2:0] SINK_XSRC = XSRC_FF;
    localparam logic [2:0] SINK_XDST = XDST_T;

    localparam int OP_ALU_BIT = 7;
    localparam int F_OOO_LSB  = 4;
    localparam int F_SUB_LSB  = 4;
    localparam int F_DD_LSB   = 2;
    localparam int F_SS_LSB   = 0;

    localparam logic [1:0] SUB_LDI = 2'b00;
    localparam logic [1:0] SUB_LD  = 2'b01;
    localparam logic [1:0] SUB_ST  = 2'b10;
    localparam logic [1:0] SUB_JCC = 2'b11;

    localparam logic [1:0] CC_ALWAYS = 2'b00;
    localparam logic [1:0] CC_Z      = 2'b01;
    localparam logic [1:0] CC_CY     = 2'b10;
    localparam logic [1:0] CC_S      = 2'b11;

    function automatic logic [2:0] reg_code(input logic [1:0] rr);
        return {1'b0, rr};
    endfunction

endpackage

// File: rtl/cdec_cond_eval.sv
// Jump condition evaluator: selects always / Z / Cy / S from the flag bus.
// Purely combinational, no backpressure.
module cdec_cond_eval
    import cdec_ctrl_pkg::*;
(
    input  logic [1:0] cc,
    input  logic [2:0] szcy,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cc)
            CC_ALWAYS: taken = 1'b1;
            CC_Z:      taken = szcy[1];
            CC_CY:     taken = szcy[0];
            CC_S:      taken = szcy[2];
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cdec_controller.sv
// CDEC control unit: fetch / increment / execute sequencer over a single Xbus.
// Outputs are combinational from state and I; no stalls, one bus move per cycle.
module cdec_controller
    import cdec_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] I,
    input  logic [2:0] SZCy,
    output logic [2:0] xsrc,
    output logic [2:0] xdst,
    output logic [3:0] aluop,
    output logic       Rwe,
    output logic       FLGwe,
    output logic       mem_we,
    output logic       halted,
    output logic [2:0] dbg_state
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic        taken;

    logic       is_alu;
    logic       is_mov;
    logic [1:0] sub_f;
    logic [1:0] dd_f;
    logic [1:0] ss_f;
    logic [2:0] ooo_f;

    assign is_alu = I[OP_ALU_BIT];
    assign is_mov = (I[7:6] == 2'b00);
    assign sub_f  = I[F_SUB_LSB +: 2];
    assign ooo_f  = I[F_OOO_LSB +: 3];
    assign dd_f   = I[F_DD_LSB +: 2];
    assign ss_f   = I[F_SS_LSB +: 2];

    cdec_cond_eval u_cond (
        .cc    (ss_f),
        .szcy  (SZCy),
        .taken (taken)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_F0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_F0;
        xsrc    = SINK_XSRC;
        xdst    = SINK_XDST;
        aluop   = ALUOP_NONE;
        Rwe     = 1'b0;
        FLGwe   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ST_F0: begin
                xsrc    = XSRC_PC;
                xdst    = XDST_MAR;
                Rwe     = 1'b1;
                aluop   = ALUOP_INC;
                state_d = ST_F1;
            end
            ST_F1: begin
                xsrc    = XSRC_RD;
                xdst    = XDST_I;
                state_d = ST_F2;
            end
            ST_F2: begin
                xsrc    = XSRC_R;
                xdst    = XDST_PC;
                state_d = (I == 8'h00) ? ST_HALT : ST_E0;
            end
            ST_E0: begin
                state_d = ST_E1;
                if (is_alu) begin
                    xsrc = reg_code(ss_f);
                    xdst = XDST_T;
                end else if (is_mov) begin
                    xsrc    = reg_code(ss_f);
                    xdst    = reg_code(dd_f);
                    state_d = ST_F0;
                end else if (sub_f == SUB_LDI || sub_f == SUB_JCC) begin
                    // Immediate operand: point MAR at it and step PC past it.
                    xsrc  = XSRC_PC;
                    xdst  = XDST_MAR;
                    Rwe   = 1'b1;
                    aluop = ALUOP_INC;
                end else begin
                    xsrc = reg_code(ss_f);
                    xdst = XDST_MAR;
                end
            end
            ST_E1: begin
                if (is_alu) begin
                    xsrc    = reg_code(dd_f);
                    xdst    = XDST_T;
                    aluop   = {1'b0, ooo_f};
                    Rwe     = 1'b1;
                    FLGwe   = 1'b1;
                    state_d = ST_E2;
                end else if (!is_mov) begin
                    case (sub_f)
                        SUB_LDI: begin
                            xsrc    = XSRC_RD;
                            xdst    = reg_code(dd_f);
                            state_d = ST_E2;
                        end
                        SUB_LD: begin
                            xsrc = XSRC_RD;
                            xdst = reg_code(dd_f);
                        end
                        SUB_ST: begin
                            xsrc    = reg_code(dd_f);
                            xdst    = XDST_WDR;
                            state_d = ST_E2;
                        end
                        default: begin
                            xsrc = taken ? XSRC_RD : XSRC_R;
                            xdst = XDST_PC;
                        end
                    endcase
                end
            end
            ST_E2: begin
                if (is_alu) begin
                    xsrc = XSRC_R;
                    xdst = reg_code(dd_f);
                end else if (!is_mov && sub_f == SUB_LDI) begin
                    xsrc = XSRC_R;
                    xdst = XDST_PC;
                end else if (!is_mov && sub_f == SUB_ST) begin
                    mem_we = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_F0;
            end
        endcase
    end

    assign halted    = (state_q == ST_HALT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cdec_controller.sv
// Bench for cdec_controller: a behavioural datapath closes the loop, directed
// programs push hand-computed per-cycle expectations into a scoreboard queue.
module tb_cdec_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] I;
    logic [2:0] SZCy;
    logic [2:0] xsrc, xdst;
    logic [3:0] aluop;
    logic       Rwe, FLGwe, mem_we, halted;
    logic [2:0] dbg_state;

    always #5 clock = ~clock;

    cdec_controller dut (
        .clock     (clock),
        .reset     (reset),
        .I         (I),
        .SZCy      (SZCy),
        .xsrc      (xsrc),
        .xdst      (xdst),
        .aluop     (aluop),
        .Rwe       (Rwe),
        .FLGwe     (FLGwe),
        .mem_we    (mem_we),
        .halted    (halted),
        .dbg_state (dbg_state)
    );

    // Behavioural datapath
    logic [7:0] pc_r, a_r, b_r, c_r, r_r, t_r, i_r, mar_r, wdr_r;
    logic [2:0] flg_r;
    logic [7:0] mem  [256];
    logic [7:0] prog [256];
    logic [7:0] init_a, init_b, init_c;
    logic [2:0] init_flg;
    logic       load;
    logic [7:0] xbus;
    int         cyc = 0;
    int         memwe_cnt = 0;
    int         errors = 0;
    int         checks = 0;

    assign I    = i_r;
    assign SZCy = flg_r;

    always_comb begin
        xbus = 8'hFF;
        case (xsrc)
            3'd0: xbus = pc_r;
            3'd1: xbus = a_r;
            3'd2: xbus = b_r;
            3'd3: xbus = c_r;
            3'd4: xbus = r_r;
            3'd5: xbus = mem[mar_r];
            3'd6: xbus = {5'b0, flg_r};
            default: xbus = 8'hFF;
        endcase
    end

    function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] x, input logic [7:0] t);
        case (op)
            4'h8:    return {1'b0, x} + 9'd1;
            4'h0:    return {1'b0, x} + {1'b0, t};
            4'h1:    return {1'b0, x} - {1'b0, t};
            default: return {1'b0, x};
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin : dp
        logic [8:0] res;
        if (!reset) begin
            pc_r <= 8'h00;
            if (load) begin
                for (int k = 0; k < 256; k++) mem[k] <= prog[k];
                a_r <= init_a; b_r <= init_b; c_r <= init_c; flg_r <= init_flg;
                r_r <= 8'h00; t_r <= 8'h00; i_r <= 8'h00; mar_r <= 8'h00; wdr_r <= 8'h00;
            end
        end else begin
            res = alu(aluop, xbus, t_r);
            case (xdst)
                3'd0: pc_r  <= xbus;
                3'd1: a_r   <= xbus;
                3'd2: b_r   <= xbus;
                3'd3: c_r   <= xbus;
                3'd4: mar_r <= xbus;
                3'd5: wdr_r <= xbus;
                3'd6: t_r   <= xbus;
                default: i_r <= xbus;
            endcase
            if (Rwe)    r_r   <= res[7:0];
            if (FLGwe)  flg_r <= {res[7], res[7:0] == 8'h00, res[8]};
            if (mem_we) mem[mar_r] <= wdr_r;
        end
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_we === 1'b1) memwe_cnt <= memwe_cnt + 1;
    end

    // Scoreboard
    typedef struct {
        int         cyc;
        int         kind;
        string      nm;
        logic [13:0] ctl;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];
    exp_t e_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] mval(input int sel);
        case (sel)
            0: return pc_r;
            1: return a_r;
            2: return b_r;
            3: return c_r;
            4: return {5'b0, flg_r};
            default: return mem[8'h80];
        endcase
    endfunction

    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e_m = q.pop_front();
            if (e_m.kind == 0)
                chk(e_m.nm, {18'b0, xsrc, xdst, aluop, Rwe, FLGwe, mem_we, halted}, {18'b0, e_m.ctl});
            else
                chk(e_m.nm, {24'b0, mval(e_m.sel)}, {24'b0, e_m.val});
        end
    end

    task automatic ex_ctrl(input string nm, input int c, input logic [2:0] xs, input logic [2:0] xd,
                           input logic [3:0] op, input logic rw, input logic fw, input logic mw, input logic h);
        exp_t e;
        e.cyc = c; e.kind = 0; e.nm = nm; e.ctl = {xs, xd, op, rw, fw, mw, h}; e.sel = 0; e.val = 0;
        q.push_back(e);
    endtask

    task automatic ex_val(input string nm, input int c, input int sel, input logic [7:0] v);
        exp_t e;
        e.cyc = c; e.kind = 1; e.nm = nm; e.ctl = 0; e.sel = sel; e.val = v;
        q.push_back(e);
    endtask

    task automatic ex_fetch(input string p, input int b);
        ex_ctrl({p, "_f0"}, b,     3'd0, 3'd4, 4'h8, 1, 0, 0, 0);
        ex_ctrl({p, "_f1"}, b + 1, 3'd5, 3'd7, 4'h0, 0, 0, 0, 0);
        ex_ctrl({p, "_f2"}, b + 2, 3'd4, 3'd0, 4'h0, 0, 0, 0, 0);
    endtask

    task automatic ex_halt_at(input string p, input int b);
        ex_fetch({p, "_hf"}, b);
        ex_ctrl({p, "_halt"}, b + 3, 3'd7, 3'd6, 4'h0, 0, 0, 0, 1);
    endtask

    task automatic clear_prog();
        for (int k = 0; k < 256; k++) prog[k] = 8'h00;
        init_a = 8'h00; init_b = 8'h00; init_c = 8'h00; init_flg = 3'b000;
    endtask

    task automatic do_reset();
        @(posedge clock); #2;
        load  = 1'b1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #2;
    endtask

    task automatic release_rst(output int b);
        reset = 1'b1;
        b = cyc;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clock);
            n++;
        end
        chk({nm, "_drain"}, q.size(), 0);
        q.delete();
    endtask

    task automatic jcc_test(input string nm, input logic [7:0] op, input logic [2:0] flg, input logic tk);
        int b;
        clear_prog();
        prog[0] = op; prog[1] = 8'h40; init_flg = flg;
        do_reset();
        release_rst(b);
        ex_fetch(nm, b);
        ex_ctrl({nm, "_e0"}, b + 3, 3'd0, 3'd4, 4'h8, 1, 0, 0, 0);
        ex_ctrl({nm, "_e1"}, b + 4, tk ? 3'd5 : 3'd4, 3'd0, 4'h0, 0, 0, 0, 0);
        ex_val({nm, "_pc"}, b + 5, 0, tk ? 8'h40 : 8'h02);
        ex_halt_at(nm, b + 5);
        drain(nm);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : stim
        int b;
        int cnt0;
        reset = 1'b0;
        load  = 1'b1;
        clear_prog();

        // Reset behaviour and HALT on 00
        do_reset();
        chk("rst_xsrc", {29'b0, xsrc}, 0);
        chk("rst_xdst", {29'b0, xdst}, 4);
        chk("rst_rwe", {31'b0, Rwe}, 1);
        chk("rst_memwe", {31'b0, mem_we}, 0);
        release_rst(b);
        ex_fetch("t1", b);
        for (int k = 0; k < 20; k++) ex_ctrl("t1_halt_hold", b + 3 + k, 3'd7, 3'd6, 4'h0, 0, 0, 0, 1);
        drain("t1");

        // LDI A,#5A
        clear_prog();
        prog[0] = 8'h44; prog[1] = 8'h5A;
        do_reset();
        release_rst(b);
        ex_fetch("ldi", b);
        ex_ctrl("ldi_e0", b + 3, 3'd0, 3'd4, 4'h8, 1, 0, 0, 0);
        ex_ctrl("ldi_e1", b + 4, 3'd5, 3'd1, 4'h0, 0, 0, 0, 0);
        ex_ctrl("ldi_e2", b + 5, 3'd4, 3'd0, 4'h0, 0, 0, 0, 0);
        ex_val("ldi_a", b + 6, 1, 8'h5A);
        ex_val("ldi_pc", b + 6, 0, 8'h02);
        ex_halt_at("ldi", b + 6);
        drain("ldi");

        // ALU 86h: A <- A + B, F0 + 20 = 110 -> A=10, Cy=1
        clear_prog();
        prog[0] = 8'h86; init_a = 8'hF0; init_b = 8'h20;
        do_reset();
        release_rst(b);
        ex_fetch("alu", b);
        ex_ctrl("alu_e0", b + 3, 3'd2, 3'd6, 4'h0, 0, 0, 0, 0);
        ex_ctrl("alu_e1", b + 4, 3'd1, 3'd6, 4'h0, 1, 1, 0, 0);
        ex_ctrl("alu_e2", b + 5, 3'd4, 3'd1, 4'h0, 0, 0, 0, 0);
        ex_val("alu_a", b + 6, 1, 8'h10);
        ex_val("alu_flg", b + 6, 4, 8'h01);
        ex_halt_at("alu", b + 6);
        drain("alu");

        // ST B,[C]
        clear_prog();
        prog[0] = 8'h6B; init_b = 8'h3C; init_c = 8'h80;
        do_reset();
        release_rst(b);
        ex_fetch("st", b);
        ex_ctrl("st_e0", b + 3, 3'd3, 3'd4, 4'h0, 0, 0, 0, 0);
        ex_ctrl("st_e1", b + 4, 3'd2, 3'd5, 4'h0, 0, 0, 0, 0);
        ex_ctrl("st_e2", b + 5, 3'd7, 3'd6, 4'h0, 0, 0, 1, 0);
        ex_val("st_mem", b + 6, 5, 8'h3C);
        ex_halt_at("st", b + 6);
        drain("st");

        // MOV A,B (06h), 4 cycles
        clear_prog();
        prog[0] = 8'h06; init_a = 8'h11; init_b = 8'hA7;
        do_reset();
        release_rst(b);
        ex_fetch("mov", b);
        ex_ctrl("mov_e0", b + 3, 3'd2, 3'd1, 4'h0, 0, 0, 0, 0);
        ex_val("mov_a", b + 4, 1, 8'hA7);
        ex_halt_at("mov", b + 4);
        drain("mov");

        // LD A,[C] (57h), 5 cycles
        clear_prog();
        prog[0] = 8'h57; prog[8'h80] = 8'h99; init_c = 8'h80;
        do_reset();
        release_rst(b);
        ex_fetch("ld", b);
        ex_ctrl("ld_e0", b + 3, 3'd3, 3'd4, 4'h0, 0, 0, 0, 0);
        ex_ctrl("ld_e1", b + 4, 3'd5, 3'd1, 4'h0, 0, 0, 0, 0);
        ex_val("ld_a", b + 5, 1, 8'h99);
        ex_halt_at("ld", b + 5);
        drain("ld");

        // Conditional jumps
        jcc_test("jz_taken", 8'h71, 3'b010, 1'b1);
        jcc_test("jz_not", 8'h71, 3'b000, 1'b0);
        jcc_test("jc_taken", 8'h72, 3'b001, 1'b1);
        jcc_test("js_not", 8'h73, 3'b011, 1'b0);

        // Reset pulsed during E1 of ST
        clear_prog();
        prog[0] = 8'h6B; init_b = 8'h3C; init_c = 8'h80;
        do_reset();
        release_rst(b);
        ex_fetch("rst_st", b);
        ex_ctrl("rst_st_e0", b + 3, 3'd3, 3'd4, 4'h0, 0, 0, 0, 0);
        repeat (4) @(posedge clock);
        #1;
        chk("rst_st_e1_xsrc", {29'b0, xsrc}, 2);
        chk("rst_st_e1_xdst", {29'b0, xdst}, 5);
        cnt0 = memwe_cnt;
        #1;
        load  = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_async_xsrc", {29'b0, xsrc}, 0);
        chk("rst_async_xdst", {29'b0, xdst}, 4);
        chk("rst_async_rwe", {31'b0, Rwe}, 1);
        chk("rst_async_memwe", {31'b0, mem_we}, 0);
        @(posedge clock); #2;
        chk("rst_mem_unchanged", {24'b0, mem[8'h80]}, 0);
        chk("rst_no_memwe", memwe_cnt, cnt0);
        release_rst(b);
        ex_fetch("rerun", b);
        ex_ctrl("rerun_e0", b + 3, 3'd3, 3'd4, 4'h0, 0, 0, 0, 0);
        ex_ctrl("rerun_e1", b + 4, 3'd2, 3'd5, 4'h0, 0, 0, 0, 0);
        ex_ctrl("rerun_e2", b + 5, 3'd7, 3'd6, 4'h0, 0, 0, 1, 0);
        ex_val("rerun_mem", b + 6, 5, 8'h3C);
        ex_halt_at("rerun", b + 6);
        drain("rerun");
        chk("memwe_total_one", memwe_cnt, cnt0 + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
